// File: rtl/ifetch_unit.sv
// Instruction fetch stage: tagged instruction buffer in front of a req/ack imem.
// Optional second (prefetch) entry enabled by defining IFETCH_PREFETCH_EN.
module ifetch_unit #(
  parameter int          ADDR_W  = 32,
  parameter int          TIMEOUT = 16,
  parameter logic [31:0] NOP     = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic              stall,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              fetch_err
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ERR
  } state_t;

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t            state;
  logic [31:0]       buf_data;
  logic [ADDR_W-1:0] tag;
  logic              buf_valid;
  logic [CW-1:0]     cnt;

  logic main_hit;
  logic pf_hit;
  logic miss;

`ifdef IFETCH_PREFETCH_EN
  logic [31:0]       pf_buf;
  logic [ADDR_W-1:0] pf_tag;
  logic              pf_valid;
  logic              pf_req;

  assign pf_hit = pf_valid && (pc == pf_tag);
`else
  assign pf_hit = 1'b0;
`endif

  assign main_hit = buf_valid && (pc == tag);
  assign miss     = ~(main_hit | pf_hit);

  // Output word select: NOP in error, else whichever entry hits
  always_comb begin
    instr_valid = 1'b0;
    instr       = buf_data;
    if (state == ERR) begin
      instr_valid = 1'b1;
      instr       = NOP;
    end else if (main_hit) begin
      instr_valid = 1'b1;
`ifdef IFETCH_PREFETCH_EN
    end else if (pf_hit) begin
      instr_valid = 1'b1;
      instr       = pf_buf;
`endif
    end
  end

  assign stall = ~instr_valid;

  // Fetch FSM, buffer fill and timeout tracking
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      buf_data  <= '0;
      tag       <= '0;
      buf_valid <= 1'b0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      fetch_err <= 1'b0;
      cnt       <= '0;
`ifdef IFETCH_PREFETCH_EN
      pf_buf    <= '0;
      pf_tag    <= '0;
      pf_valid  <= 1'b0;
      pf_req    <= 1'b0;
`endif
    end else begin
`ifdef IFETCH_PREFETCH_EN
      if (state != ERR && pf_hit && !main_hit) begin
        buf_data  <= pf_buf;
        tag       <= pf_tag;
        buf_valid <= 1'b1;
        pf_valid  <= 1'b0;
      end
`endif
      unique case (state)
        IDLE: begin
          if (miss) begin
            if (pc[1:0] != 2'b00) begin
              state     <= ERR;
              fetch_err <= 1'b1;
            end else begin
              state    <= REQ;
              mem_req  <= 1'b1;
              mem_addr <= pc;
              cnt      <= '0;
`ifdef IFETCH_PREFETCH_EN
              pf_req   <= 1'b0;
`endif
            end
`ifdef IFETCH_PREFETCH_EN
          end else if (!pf_valid) begin
            state    <= REQ;
            mem_req  <= 1'b1;
            mem_addr <= tag + ADDR_W'(4);
            cnt      <= '0;
            pf_req   <= 1'b1;
`endif
          end
        end
        REQ: begin
          if (mem_ack) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            if (mem_addr == pc) begin
              buf_data  <= mem_rdata;
              tag       <= mem_addr;
              buf_valid <= 1'b1;
`ifdef IFETCH_PREFETCH_EN
            end else if (pf_req && main_hit) begin
              pf_buf   <= mem_rdata;
              pf_tag   <= mem_addr;
              pf_valid <= 1'b1;
`endif
            end
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            state     <= ERR;
            mem_req   <= 1'b0;
            fetch_err <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ERR: begin
          state   <= ERR;
          mem_req <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed stimulus, queue scoreboard for
// memory requests and delivered instructions, plus cycle-exact checks.
module tb_ifetch_unit;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        fetch_err;

  int total = 0;
  int bad   = 0;

  logic        ack_en;
  int          ack_delay;
  logic [31:0] req_q[$];
  logic [32:0] dat_q[$];

  ifetch_unit dut (
    .clk(clk),
    .rst(rst),
    .pc(pc),
    .instr(instr),
    .instr_valid(instr_valid),
    .stall(stall),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .fetch_err(fetch_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h2008_0005;
      32'h0000_0004: return 32'h0000_AAAA;
      32'h0000_0040: return 32'h1234_5678;
      32'h0000_0010: return 32'h1111_2222;
      32'h0000_0014: return 32'h3333_4444;
      32'h0000_0018: return 32'h5555_6666;
      default:       return ~a;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Memory model: ack ack_delay cycles into a request
  initial begin
    int wcnt;
    wcnt      = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      mem_ack = 1'b0;
      if (mem_req && ack_en) begin
        if (wcnt == ack_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_word(mem_addr);
          wcnt      = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Monitor: pop expectations on new requests and new deliveries
  initial begin
    logic        p_req;
    logic        p_val;
    logic [31:0] p_ins;
    logic [31:0] ea;
    logic [32:0] ed;
    p_req = 1'b0;
    p_val = 1'b0;
    p_ins = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (mem_req && !p_req) begin
          if (req_q.size() == 0) begin
            check("sb_unexpected_req", {32'h0, mem_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            ea = req_q.pop_front();
            check("sb_req_addr", {32'h0, mem_addr}, {32'h0, ea});
          end
        end
        if (instr_valid && (!p_val || instr != p_ins)) begin
          if (dat_q.size() == 0) begin
            check("sb_unexpected_instr", {32'h0, instr}, 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            ed = dat_q.pop_front();
            check("sb_instr", {31'h0, fetch_err, instr}, {31'h0, ed});
          end
        end
      end
      p_req = mem_req;
      p_val = instr_valid;
      p_ins = instr;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b0;
    pc        = '0;
    ack_en    = 1'b1;
    ack_delay = 1;
    repeat (3) @(posedge clk);
    smp();
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_instr", instr, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_stall", stall, 1);
    check("rst_err", fetch_err, 0);

`ifdef IFETCH_PREFETCH_EN
    pc = 32'h10;
    req_q.push_back(32'h10);
    req_q.push_back(32'h14);
    req_q.push_back(32'h18);
    dat_q.push_back({1'b0, 32'h1111_2222});
    dat_q.push_back({1'b0, 32'h3333_4444});
    adv(); rst = 1'b1; smp();
    adv(); smp();
    check("pf_c1_req", mem_req, 1);
    check("pf_c1_addr", mem_addr, 32'h10);
    adv(); adv(); smp();
    check("pf_c3_valid", instr_valid, 1);
    check("pf_c3_instr", instr, 32'h1111_2222);
    adv(); smp();
    check("pf_c4_req", mem_req, 1);
    check("pf_c4_addr", mem_addr, 32'h14);
    check("pf_c4_valid", instr_valid, 1);
    adv(); adv(); smp();
    check("pf_c6_req", mem_req, 0);
    adv(); pc = 32'h14; smp();
    check("pf_c7_valid", instr_valid, 1);
    check("pf_c7_instr", instr, 32'h3333_4444);
    check("pf_c7_stall", stall, 0);
    check("pf_c7_req", mem_req, 0);
    adv(); smp();
    check("pf_c8_instr", instr, 32'h3333_4444);
    check("pf_c8_req", mem_req, 0);
    adv(); smp();
    check("pf_c9_req", mem_req, 1);
    check("pf_c9_addr", mem_addr, 32'h18);
`else
    // basic fill, ack one cycle after request
    req_q.push_back(32'h0);
    dat_q.push_back({1'b0, 32'h2008_0005});
    adv(); rst = 1'b1; smp();
    check("t1_c0_req", mem_req, 0);
    check("t1_c0_stall", stall, 1);
    adv(); smp();
    check("t1_c1_req", mem_req, 1);
    check("t1_c1_addr", mem_addr, 32'h0);
    adv(); smp();
    check("t1_c2_valid", instr_valid, 0);
    adv(); smp();
    check("t1_c3_valid", instr_valid, 1);
    check("t1_c3_instr", instr, 32'h2008_0005);
    check("t1_c3_stall", stall, 0);

    // hit: no further requests
    for (int i = 0; i < 5; i++) begin
      adv(); smp();
      check("t2_req", mem_req, 0);
      check("t2_instr", instr, 32'h2008_0005);
      check("t2_stall", stall, 0);
    end

    // redirect while waiting
    ack_en    = 1'b0;
    ack_delay = 0;
    req_q.push_back(32'h4);
    req_q.push_back(32'h40);
    dat_q.push_back({1'b0, 32'h1234_5678});
    adv(); pc = 32'h4; smp();
    check("t3_miss_valid", instr_valid, 0);
    check("t3_miss_stall", stall, 1);
    adv(); smp();
    check("t3_req4", mem_req, 1);
    check("t3_addr4", mem_addr, 32'h4);
    adv(); pc = 32'h40; ack_en = 1'b1; smp();
    check("t3_hold_req", mem_req, 1);
    check("t3_hold_addr", mem_addr, 32'h4);
    check("t3_ack_valid", instr_valid, 0);
    adv(); smp();
    check("t3_discard_req", mem_req, 0);
    check("t3_discard_valid", instr_valid, 0);
    adv(); smp();
    check("t3_req40", mem_req, 1);
    check("t3_addr40", mem_addr, 32'h40);
    check("t3_wait_valid", instr_valid, 0);
    adv(); smp();
    check("t3_valid", instr_valid, 1);
    check("t3_instr", instr, 32'h1234_5678);

    // timeout
    ack_en = 1'b0;
    req_q.push_back(32'h8);
    dat_q.push_back({1'b1, 32'h0});
    adv(); pc = 32'h8; smp();
    check("t4_miss_valid", instr_valid, 0);
    for (int i = 1; i <= 16; i++) begin
      adv(); smp();
      check("t4_req_hold", mem_req, 1);
      check("t4_no_err", fetch_err, 0);
    end
    adv(); smp();
    check("t4_req_drop", mem_req, 0);
    check("t4_err", fetch_err, 1);
    check("t4_valid", instr_valid, 1);
    check("t4_instr", instr, 32'h0);
    check("t4_stall", stall, 0);
    ack_en = 1'b1;
    adv(); pc = 32'h0;
    for (int i = 0; i < 4; i++) begin
      adv(); smp();
      check("t4_sticky_err", fetch_err, 1);
      check("t4_sticky_req", mem_req, 0);
      check("t4_sticky_instr", instr, 32'h0);
    end
    #2 rst = 1'b0;
    #1;
    check("t4_arst_err", fetch_err, 0);
    check("t4_arst_valid", instr_valid, 0);
    check("t4_arst_stall", stall, 1);

    // misaligned pc
    dat_q.push_back({1'b1, 32'h0});
    pc = 32'h6;
    adv(); rst = 1'b1; smp();
    check("t5_c0_err", fetch_err, 0);
    check("t5_c0_req", mem_req, 0);
    adv(); smp();
    check("t5_c1_err", fetch_err, 1);
    check("t5_c1_req", mem_req, 0);
    check("t5_c1_valid", instr_valid, 1);
    check("t5_c1_stall", stall, 0);
    adv(); smp();
    check("t5_c2_req", mem_req, 0);

    // async reset in the middle of a request
    rst    = 1'b0;
    pc     = 32'h8;
    ack_en = 1'b0;
    req_q.push_back(32'h8);
    adv(); rst = 1'b1;
    adv(); adv(); smp();
    check("t5_mid_req", mem_req, 1);
    check("t5_mid_addr", mem_addr, 32'h8);
    #2 rst = 1'b0;
    #1;
    check("t5_arst_req", mem_req, 0);
    check("t5_arst_addr", mem_addr, 32'h0);
    check("t5_arst_err", fetch_err, 0);
`endif

    repeat (3) smp();
    check("sb_req_left", req_q.size(), 0);
    check("sb_dat_left", dat_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
